// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the serial ADC sample sequencer.
// cnt_width() gives the bits needed to hold the values 0..n-1.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        LOAD,
        QUIET
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;

    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider: CLK_DIV system clocks per half-period, idles high, and
// restarts at the beginning of a low phase when load_i is pulsed.
module adc_sclk_gen
    import adc_seq_pkg::*;
#(
    parameter int CLK_DIV = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    input  logic last_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] PH_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          ph_end;

    assign ph_end = en_i && (cnt_q == PH_LAST);
    assign rise_o = ph_end && !sclk_q;
    assign fall_o = ph_end && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (load_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (ph_end) begin
                cnt_d  = '0;
                // The final high phase of a frame must not fall back low.
                sclk_d = !sclk_q || last_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d  = '0;
            sclk_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Master-side controller for a 16-SCLK serial ADC frame: paces conversions,
// deserialises SDATA and hands each 12-bit result to a one-entry buffer.
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int QUIET_CLKS    = 8
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    localparam int PW = cnt_width((CLK_DIV > QUIET_CLKS) ? CLK_DIV : QUIET_CLKS);
    localparam int TW = cnt_width(SAMPLE_PERIOD);
    localparam int BW = cnt_width(FRAME_BITS + 1);
    localparam logic [PW-1:0] SETUP_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] QUIET_LAST = PW'(QUIET_CLKS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [BW-1:0] BITS_ALL   = BW'(FRAME_BITS);

    state_t               state_q, state_d;
    logic [PW-1:0]        ph_q, ph_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;

    logic trigger, setup_done, shift_done, quiet_done;
    logic sclk_rise, sclk_fall, load, xfer;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .load_i (setup_done),
        .en_i   (state_q == SHIFT),
        .last_i (bit_cnt_q == BITS_ALL),
        .sclk_o (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // A timer wrap or start outside IDLE is simply dropped.
    assign trigger    = (state_q == IDLE) && (enable ? (timer_q == '0) : start);
    assign setup_done = (state_q == SETUP) && (ph_q == SETUP_LAST);
    assign shift_done = sclk_fall && (bit_cnt_q == BITS_ALL);
    assign quiet_done = (state_q == QUIET) && (ph_q == QUIET_LAST);
    assign load       = (state_q == LOAD);
    assign xfer       = valid_q && sample_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger)    state_d = SETUP;
            SETUP:   if (setup_done) state_d = SHIFT;
            SHIFT:   if (shift_done) state_d = LOAD;
            LOAD:                    state_d = QUIET;
            QUIET:   if (quiet_done) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_n_d = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            IDLE:         busy_d = 1'b0;
            SETUP, SHIFT: cs_n_d = 1'b0;
            default:      ;
        endcase
    end

    always_comb begin
        ph_d      = ((state_d != state_q) || (state_q == IDLE)) ? '0 : ph_q + 1'b1;
        timer_d   = (!enable || (timer_q == TIMER_LAST)) ? '0 : timer_q + 1'b1;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        // Only the last 12 bits shifted in survive; the leading zeros fall off.
        if (trigger) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[DATA_BITS-2:0], sdata};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        data_d    = load ? shift_q : data_q;
        valid_d   = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
        overrun_d = (load && valid_q && !sample_ready) ? 1'b1 :
                    (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q      <= '0;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
        end
    end

    assign cs_n         = cs_n_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with an ADC pin model, a result
// scoreboard and a frame monitor checking SCLK count and CS quiet time.
module tb_adc_sample_sequencer;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 100;
    localparam int QUIET_CLKS    = 8;
    localparam int FRAME_CLKS    = CLK_DIV + 32 * CLK_DIV + 1 + QUIET_CLKS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        sdata = 1'b0;
    logic        sample_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        cs_n, sclk, sample_valid, overrun, busy;
    logic [11:0] sample_data;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int frames = 0;
    int fall_cyc[$];
    logic [15:0] adc_q[$];
    logic [11:0] exp_q[$];

    adc_sample_sequencer #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .QUIET_CLKS    (QUIET_CLKS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .sdata        (sdata),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ADC pin model: word loaded on CS fall, one bit presented per SCLK fall.
    logic [15:0] cur_word = 16'h0;
    int          bit_idx = -1;
    always @(negedge cs_n) begin
        cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0;
        bit_idx  = 15;
    end
    always @(negedge sclk) begin
        if (!cs_n && bit_idx >= 0) begin
            #1 sdata = cur_word[bit_idx];
            bit_idx--;
        end
    end

    // Scoreboard: every accepted result is compared with the queued expectation.
    always @(negedge clk) begin
        if (!reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_xfer: got 0x%03h expected no transfer", sample_data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                $display("xfer cyc=%0d data=0x%03h expected=0x%03h", cyc, sample_data, e);
                check("xfer_data", int'(sample_data), int'(e));
            end
        end
    end

    // Frame monitor: SCLK rises per frame and CS high time between frames.
    logic prev_cs = 1'b1, prev_sclk = 1'b1, in_frame = 1'b0;
    int   rises = 0, hi_cnt = 1000;
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
            rises    = 0;
            hi_cnt   = 1000;
        end else begin
            if (prev_cs && !cs_n) begin
                frames++;
                fall_cyc.push_back(cyc);
                $display("frame %0d start cyc=%0d cs_high=%0d", frames, cyc, hi_cnt);
                check("quiet_gap", int'(hi_cnt >= QUIET_CLKS), 1);
                rises    = 0;
                in_frame = 1'b1;
            end
            if (!cs_n && !prev_sclk && sclk) rises++;
            if (cs_n && !prev_cs && in_frame) begin
                check("sclk_rises", rises, 16);
                in_frame = 1'b0;
            end
            hi_cnt = cs_n ? hi_cnt + 1 : 0;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    function automatic int get_fall(input int i);
        return (i < fall_cyc.size()) ? fall_cyc[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("idle_in_time", int'(n < 300), 1);
    endtask

    task automatic accept_one();
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, f0, t_en;
        logic ps;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 1);
        check("rst_data", sample_data, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);

        // Single shot
        adc_q.push_back(16'h0ABC);
        pulse_start();
        check("ss_cs_low", cs_n, 0);
        check("ss_setup_sclk", sclk, 1);
        check("ss_busy", busy, 1);
        tick();
        check("ss_setup_sclk2", sclk, 1);
        tick();
        check("ss_first_fall", sclk, 0);
        wait_idle(n);
        check("ss_frame_len", n + 2, FRAME_CLKS);
        check("ss_valid", sample_valid, 1);
        check("ss_data", sample_data, 12'hABC);
        check("ss_overrun", overrun, 0);
        exp_q.push_back(12'hABC);
        accept_one();
        check("ss_valid_drop", sample_valid, 0);

        // Continuous mode
        adc_q.push_back(16'h0001); adc_q.push_back(16'h0002); adc_q.push_back(16'h0003);
        exp_q.push_back(12'h001); exp_q.push_back(12'h002); exp_q.push_back(12'h003);
        sample_ready = 1'b1;
        f0 = frames;
        enable = 1'b1;
        t_en = cyc;
        n = 0;
        while (frames < f0 + 3 && n < 400) begin
            tick();
            n++;
        end
        check("cont_frames", frames - f0, 3);
        enable = 1'b0;
        wait_idle(n);
        check("cont_first", get_fall(f0) - t_en, 1);
        check("cont_gap1", get_fall(f0 + 1) - get_fall(f0), SAMPLE_PERIOD);
        check("cont_gap2", get_fall(f0 + 2) - get_fall(f0 + 1), SAMPLE_PERIOD);
        check("cont_overrun", overrun, 0);
        check("cont_drained", exp_q.size(), 0);
        sample_ready = 1'b0;

        // Overrun
        adc_q.push_back(16'h0123); adc_q.push_back(16'h0456);
        pulse_start(); wait_idle(n);
        pulse_start(); wait_idle(n);
        check("ovr_data", sample_data, 12'h456);
        check("ovr_valid", sample_valid, 1);
        check("ovr_flag", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clear", overrun, 0);
        exp_q.push_back(12'h456);
        accept_one();
        check("ovr_valid_drop", sample_valid, 0);

        // Accept coinciding with LOAD
        adc_q.push_back(16'h0777);
        pulse_start(); wait_idle(n);
        check("coin_first", sample_data, 12'h777);
        exp_q.push_back(12'h777);
        adc_q.push_back(16'h0321);
        pulse_start();
        repeat (CLK_DIV + 32 * CLK_DIV) tick();
        accept_one();
        check("coin_valid", sample_valid, 1);
        check("coin_data", sample_data, 12'h321);
        check("coin_overrun", overrun, 0);
        wait_idle(n);

        // Reset mid-frame after the 7th SCLK rise
        adc_q.push_back(16'h0AAA);
        pulse_start();
        r = 0; n = 0; ps = sclk;
        while (r < 7 && n < 200) begin
            tick();
            n++;
            if (sclk && !ps) r++;
            ps = sclk;
        end
        check("mid_rises", r, 7);
        reset = 1'b1;
        #1;
        check("mid_cs_n", cs_n, 1);
        check("mid_sclk", sclk, 1);
        check("mid_valid", sample_valid, 0);
        check("mid_busy", busy, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        adc_q.push_back(16'h0FFF);
        exp_q.push_back(12'hFFF);
        pulse_start(); wait_idle(n);
        check("mid_clean_valid", sample_valid, 1);
        accept_one();
        check("mid_clean_drop", sample_valid, 0);

        // Start while busy, then a timer wrap while busy
        sample_ready = 1'b1;
        adc_q.push_back(16'h0111); exp_q.push_back(12'h111);
        f0 = frames;
        pulse_start();
        repeat (10) tick();
        pulse_start();
        wait_idle(n);
        check("busy_start_frames", frames - f0, 1);
        adc_q.push_back(16'h0222); adc_q.push_back(16'h0333);
        exp_q.push_back(12'h222); exp_q.push_back(12'h333);
        f0 = frames;
        pulse_start();
        repeat (20) tick();
        enable = 1'b1;
        t_en = cyc;
        n = 0;
        while (frames < f0 + 2 && n < 300) begin
            tick();
            n++;
        end
        enable = 1'b0;
        wait_idle(n);
        check("wrap_frames", frames - f0, 2);
        check("wrap_dropped", get_fall(f0 + 1) - t_en, SAMPLE_PERIOD + 1);
        sample_ready = 1'b0;
        tick();
        check("final_drained", exp_q.size(), 0);
        check("final_overrun", overrun, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
